// File: rtl/turbo_encoder_if.sv
// Stream bundle for turbo_encoder: bit-serial load side and symbol output side.
// Symbol fields are W bits wide when TURBO_ENC_BPSK_MAP_EN is defined, else 1 bit.
interface turbo_encoder_if #(parameter int W = 16);
`ifdef TURBO_ENC_BPSK_MAP_EN
    localparam int DW = W;
`else
    localparam int DW = 1;
`endif

    logic          in_valid;
    logic          in_bit;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_sys;
    logic [DW-1:0] out_p1;
    logic [DW-1:0] out_p2;
    logic [DW-1:0] out_sys2;
    logic          out_tail;
    logic          out_last;

    modport slave (
        input  in_valid, in_bit, out_ready,
        output in_ready, out_valid, out_sys, out_p1, out_p2, out_sys2, out_tail, out_last
    );

    modport master (
        output in_valid, in_bit, out_ready,
        input  in_ready, out_valid, out_sys, out_p1, out_p2, out_sys2, out_tail, out_last
    );
endinterface

// File: rtl/turbo_encoder.sv
// Rate-1/3 turbo encoder (two 8-state RSCs, QPP interleaver, 3-step termination); optional BPSK map: TURBO_ENC_BPSK_MAP_EN.
// Latency: first symbol the cycle after the 256th input bit; then 259 symbols at up to one per cycle.
// Backpressure: out_ready low freezes all state and outputs; in_ready is low until the tail completes.
module turbo_encoder #(
    parameter int           K   = 256,
    parameter int           W   = 16,
    parameter logic [W-1:0] AMP = 16'd256
) (
    input  logic            clk,
    input  logic            rst_n,
    turbo_encoder_if.slave  bus
);
    localparam int AW = $clog2(K);

    typedef enum logic [1:0] {S_LOAD, S_ENCODE, S_TAIL} state_t;

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_cnt, r_pi, r_g;
    logic [2:0]    r_s1, r_s2;
    logic [K-1:0]  r_u;

    logic w_out_valid, w_in_ready, w_tail, w_last;
    logic w_a1, w_a2, w_sys2;
    logic w_f1, w_f2, w_z1, w_z2;
    logic w_sys_b, w_p1_b, w_p2_b, w_sys2_b;

    always_comb begin
        w_state_nxt = r_state;
        w_out_valid = 1'b0;
        w_in_ready  = 1'b0;
        w_tail      = 1'b0;
        w_last      = 1'b0;
        w_a1        = r_u[r_cnt];
        w_a2        = r_u[r_pi];
        w_sys2      = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && r_cnt == AW'(K-1)) w_state_nxt = S_ENCODE;
            end
            S_ENCODE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready && r_cnt == AW'(K-1)) w_state_nxt = S_TAIL;
            end
            S_TAIL: begin
                // Feedback input cancels the recursion so each encoder flushes to 000
                w_out_valid = 1'b1;
                w_tail      = 1'b1;
                w_a1        = r_s1[1] ^ r_s1[0];
                w_a2        = r_s2[1] ^ r_s2[0];
                w_sys2      = w_a2;
                w_last      = (r_cnt == AW'(2));
                if (bus.out_ready && w_last) w_state_nxt = S_LOAD;
            end
            default: w_state_nxt = S_LOAD;
        endcase
    end

    // State bits are {d1,d2,d3}
    assign w_f1 = w_a1 ^ r_s1[1] ^ r_s1[0];
    assign w_z1 = w_f1 ^ r_s1[2] ^ r_s1[0];
    assign w_f2 = w_a2 ^ r_s2[1] ^ r_s2[0];
    assign w_z2 = w_f2 ^ r_s2[2] ^ r_s2[0];

    assign w_sys_b  = w_out_valid & w_a1;
    assign w_p1_b   = w_out_valid & w_z1;
    assign w_p2_b   = w_out_valid & w_z2;
    assign w_sys2_b = w_out_valid & w_sys2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOAD;
            r_cnt   <= '0;
            r_pi    <= '0;
            r_g     <= AW'(47);
            r_s1    <= '0;
            r_s2    <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_LOAD: begin
                    r_pi <= '0;
                    r_g  <= AW'(47);
                    r_s1 <= '0;
                    r_s2 <= '0;
                    if (bus.in_valid) r_cnt <= r_cnt + AW'(1);
                end
                S_ENCODE: begin
                    if (bus.out_ready) begin
                        r_s1  <= {w_f1, r_s1[2], r_s1[1]};
                        r_s2  <= {w_f2, r_s2[2], r_s2[1]};
                        r_cnt <= r_cnt + AW'(1);
                        r_pi  <= r_pi + r_g;
                        r_g   <= r_g + AW'(64);
                    end
                end
                S_TAIL: begin
                    if (bus.out_ready) begin
                        r_s1  <= {w_f1, r_s1[2], r_s1[1]};
                        r_s2  <= {w_f2, r_s2[2], r_s2[1]};
                        r_cnt <= w_last ? '0 : r_cnt + AW'(1);
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    // Block buffer needs no reset: it is fully rewritten before it is read
    always_ff @(posedge clk) begin
        if (r_state == S_LOAD && bus.in_valid) r_u[r_cnt] <= bus.in_bit;
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_tail  = w_tail;
    assign bus.out_last  = w_last;

`ifdef TURBO_ENC_BPSK_MAP_EN
    function automatic logic [W-1:0] f_map(input logic b);
        return b ? -AMP : AMP;
    endfunction

    assign bus.out_sys  = f_map(w_sys_b);
    assign bus.out_p1   = f_map(w_p1_b);
    assign bus.out_p2   = f_map(w_p2_b);
    assign bus.out_sys2 = f_map(w_sys2_b);
`else
    assign bus.out_sys  = w_sys_b;
    assign bus.out_p1   = w_p1_b;
    assign bus.out_p2   = w_p2_b;
    assign bus.out_sys2 = w_sys2_b;
`endif
endmodule

// File: tb/tb_turbo_encoder.sv
// Randomized bench for turbo_encoder against a closed-form QPP / RSC reference model.
module tb_turbo_encoder;
    localparam int           W   = 16;
    localparam logic [W-1:0] AMP = 16'd256;
`ifdef TURBO_ENC_BPSK_MAP_EN
    localparam int DW = W;
`else
    localparam int DW = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    turbo_encoder_if #(.W(W)) bus ();

    turbo_encoder #(.K(256), .W(W), .AMP(AMP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    bit            blk     [256];
    logic [127:0]  exp_sym [259];
    logic [DW-1:0] obs_sys [259];
    logic [DW-1:0] obs_p1  [259];
    logic [DW-1:0] obs_p2  [259];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mp(input bit b);
`ifdef TURBO_ENC_BPSK_MAP_EN
        return b ? DW'(16'hFF00) : DW'(16'h0100);
`else
        return DW'(b);
`endif
    endfunction

    function automatic logic [127:0] pk(input logic t, input logic l, input logic [DW-1:0] s,
                                        input logic [DW-1:0] p1, input logic [DW-1:0] p2,
                                        input logic [DW-1:0] s2);
        return 128'({t, l, s, p1, p2, s2});
    endfunction

    function automatic logic [127:0] pk_obs();
        return pk(bus.out_tail, bus.out_last, bus.out_sys, bus.out_p1, bus.out_p2, bus.out_sys2);
    endfunction

    // QPP with f1=15, f2=32: pi(i) = (15 i + 32 i^2) mod 256
    function automatic int pi_of(input int i);
        return (15 * i + 32 * i * i) % 256;
    endfunction

    task automatic build_model();
        bit a1 [3];
        bit a2 [3];
        for (int j = 0; j < 3; j++) begin a1[j] = 0; a2[j] = 0; end
        for (int i = 0; i < 259; i++) begin
            bit x1, x2, f1, f2, z1, z2;
            if (i < 256) begin
                x1 = blk[i];
                x2 = blk[pi_of(i)];
            end else begin
                x1 = a1[1] ^ a1[2];
                x2 = a2[1] ^ a2[2];
            end
            f1 = x1 ^ a1[1] ^ a1[2];
            z1 = f1 ^ a1[0] ^ a1[2];
            f2 = x2 ^ a2[1] ^ a2[2];
            z2 = f2 ^ a2[0] ^ a2[2];
            a1[2] = a1[1]; a1[1] = a1[0]; a1[0] = f1;
            a2[2] = a2[1]; a2[1] = a2[0]; a2[0] = f2;
            exp_sym[i] = pk(i >= 256, i == 258, mp(x1), mp(z1), mp(z2), mp((i >= 256) ? x2 : 1'b0));
        end
    endtask

    task automatic load_block();
        int i = 0;
        int guard = 0;
        while (i < 256 && guard < 5000) begin
            @(negedge clk);
            guard++;
            if (i == 0) check("in_ready_load", 128'(bus.in_ready), 128'(1));
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_bit   = blk[i];
            if (bus.in_valid) i++;
        end
        if (i < 256) check("load_timeout", 128'(i), 128'(256));
    endtask

    // stop_at >= 0 leaves the loop once that symbol index is current
    task automatic drain(input int stop_at, input int ready_pct);
        int idx = 0;
        int guard = 0;
        while (idx < 259 && guard < 5000) begin
            @(negedge clk);
            if (stop_at >= 0 && idx == stop_at) break;
            guard++;
            check("out_valid", 128'(bus.out_valid), 128'(1));
            if (bus.out_valid) begin
                check("symbol", pk_obs(), exp_sym[idx]);
                obs_sys[idx] = bus.out_sys;
                obs_p1[idx]  = bus.out_p1;
                obs_p2[idx]  = bus.out_p2;
            end
            bus.out_ready = ($urandom_range(0, 99) < ready_pct);
            if (bus.out_valid && bus.out_ready) idx++;
            bus.in_valid = (idx < 259) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.in_bit   = 1'($urandom_range(0, 1));
        end
        if (stop_at < 0) begin
            check("drain_count", 128'(idx), 128'(259));
            if (ready_pct >= 100) check("throughput", 128'(guard), 128'(259));
            @(negedge clk);
            bus.out_ready = 1'b0;
            check("idle_valid", 128'(bus.out_valid), 128'(0));
            check("idle_ready", 128'(bus.in_ready), 128'(1));
        end
    endtask

    task automatic run_block(input int ready_pct);
        build_model();
        load_block();
        drain(-1, ready_pct);
    endtask

    task automatic clear_blk();
        for (int i = 0; i < 256; i++) blk[i] = 0;
    endtask

    task automatic rand_blk();
        for (int i = 0; i < 256; i++) blk[i] = 1'($urandom_range(0, 1));
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_bit    = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  128'(bus.in_ready),  128'(1));
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_tail",      128'(bus.out_tail),  128'(0));
        check("rst_last",      128'(bus.out_last),  128'(0));
        check("rst_data", pk_obs(), pk(1'b0, 1'b0, mp(0), mp(0), mp(0), mp(0)));
        rst_n = 1'b1;

        clear_blk();
        run_block(100);

        clear_blk();
        blk[0] = 1;
        run_block(70);
        check("u0_sys0", 128'(obs_sys[0]), 128'(mp(1)));
        check("u0_sys1", 128'(obs_sys[1]), 128'(mp(0)));
        check("u0_sys2", 128'(obs_sys[2]), 128'(mp(0)));
        check("u0_p1_0", 128'(obs_p1[0]),  128'(mp(1)));
        check("u0_p1_1", 128'(obs_p1[1]),  128'(mp(1)));
        check("u0_p1_2", 128'(obs_p1[2]),  128'(mp(1)));
        check("u0_p2_0", 128'(obs_p2[0]),  128'(mp(1)));

        clear_blk();
        blk[47] = 1;
        run_block(70);
        check("u47_p2_0", 128'(obs_p2[0]), 128'(mp(0)));
        check("u47_p2_1", 128'(obs_p2[1]), 128'(mp(1)));

        clear_blk();
        blk[158] = 1;
        run_block(70);
        check("u158_p2_0", 128'(obs_p2[0]), 128'(mp(0)));
        check("u158_p2_1", 128'(obs_p2[1]), 128'(mp(0)));
        check("u158_p2_2", 128'(obs_p2[2]), 128'(mp(1)));

        for (int b = 0; b < 5; b++) begin
            rand_blk();
            run_block(50);
        end

        rand_blk();
        build_model();
        load_block();
        drain(100, 50);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 128'(bus.out_valid), 128'(0));
        check("mid_rst_ready", 128'(bus.in_ready),  128'(1));
        check("mid_rst_tail",  128'(bus.out_tail),  128'(0));
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        rand_blk();
        run_block(50);
        rand_blk();
        run_block(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
